div_period_meter: RTL and testbench
===================================

DIV_PERIOD_METER -- requirements
Module: div_period_meter

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on sig_in, legal range 2..3.
REQ-002 Parameter LOCK_COUNT, default 4: consecutive in-tolerance measurements needed to assert locked, legal range 1..15.
REQ-003 Parameter TOL, default 1: allowed |period - expected| in clk cycles, legal range 0..3.
REQ-004 clk  in  1  single block clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 en  in  1  measurement enable, synchronous to clk.
REQ-007 sig_in  in  1  divided-clock input, asynchronous to clk.
REQ-008 ndiv_exp  in  4  expected divide ratio programmed into the companion divider.
REQ-009 period  out  6  last measured sig_in period in clk cycles.
REQ-010 period_valid  out  1  one-cycle pulse when period updates.
REQ-011 overflow  out  1  sticky flag: no edge seen within 63 cycles.
REQ-012 locked  out  1  measured period matches expected for LOCK_COUNT consecutive periods.

Function
REQ-013 sig_in SHALL pass through SYNC_STAGES flops, then a one-flop rising-edge detector producing edge_p.
REQ-014 FSM states SHALL be IDLE, ARM and MEASURE.
REQ-015 IDLE -> ARM when en=1; any state -> IDLE when en=0.
REQ-016 ARM: on edge_p, clear cycle counter to 1 and go to MEASURE; no period_valid from ARM.
REQ-017 MEASURE: counter increments by 1 each cycle without edge_p, saturating at 63.
REQ-018 MEASURE with edge_p: period <= counter, period_valid <= 1 next cycle, counter <= 1, overflow <= 0; period therefore equals the cycle distance between consecutive edge_p pulses.
REQ-019 MEASURE with counter = 63 and no edge_p: overflow <= 1, locked <= 0, match count <= 0, go to ARM; period unchanged.
REQ-020 Expected period SHALL be exp = 2*((ndiv_exp >> 1) + 1), computed in 6 bits (range 2..16).
REQ-021 On each period update: if |period_new - exp| <= TOL, increment match count saturating at LOCK_COUNT, otherwise clear match count; locked = (match count == LOCK_COUNT).
REQ-022 A change of ndiv_exp from its previous registered value SHALL clear match count and locked in the next cycle; any in-flight measurement continues.
REQ-023 Leaving MEASURE for IDLE SHALL clear counter, match count, locked and overflow; period keeps its last value.
REQ-024 Latency: sig_in high at a clk edge -> period_valid high SYNC_STAGES+2 cycles later.

Reset
REQ-025 rst_n=0 SHALL immediately force: state IDLE, synchronizer and edge flops 0, counter 0, match count 0, period 0, period_valid 0, overflow 0, locked 0.
REQ-026 Reset mid-measurement SHALL discard the partial count; the first edge after release only arms.

Structure
REQ-027 Shared package SHALL hold the FSM state enum, the period width constant (6), and the saturation value (63).
REQ-028 The sig_in synchronizer plus edge detector SHALL be one sub-module, sync_edge_detect, parameterized by SYNC_STAGES.

Verification
REQ-029 sig_in from a divider with ndiv=4, ndiv_exp=4, en=1 -> period=6 on every valid; locked=1 on the 4th valid; first edge produces no valid.
REQ-030 sig_in period 10, ndiv_exp=4 -> period=10 each valid, locked stays 0; period 7 with TOL=1 -> locked=1 after 4 valids.
REQ-031 sig_in held low after lock -> overflow=1 and locked=0 exactly 63 cycles after last edge_p; resuming edges -> one arming edge, then valid with overflow=0.
REQ-032 rst_n pulsed low mid-period -> all outputs 0 asynchronously; after release the first valid arrives on the second edge.
REQ-033 en dropped while locked -> locked=0, overflow=0 next cycle, period retained; ndiv_exp changed 4->6 while locked -> locked=0 next cycle, relocks to exp=8 after 4 valids.

Source files
------------

// File: rtl/div_period_meter_pkg.sv
// Shared types, widths and helpers for the divided-clock period meter.
// Everything the top and the synchronizer need to agree on lives here.
package div_period_meter_pkg;

  localparam int PERIOD_W = 6;
  localparam logic [PERIOD_W-1:0] PERIOD_SAT = 6'd63;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  // The companion divider rounds odd ratios up, so the period is 2*(n/2 + 1).
  function automatic logic [PERIOD_W-1:0] exp_period(input logic [3:0] ndiv);
    logic [PERIOD_W-1:0] half;
    half = ({2'b00, ndiv} >> 1) + 6'd1;
    return half << 1;
  endfunction

  function automatic logic [PERIOD_W-1:0] abs_diff(input logic [PERIOD_W-1:0] a,
                                                    input logic [PERIOD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/div_period_meter_sync_edge_detect.sv
// Brings the asynchronous divided clock into the clk domain and emits a
// single-cycle registered pulse on each of its rising edges.
module sync_edge_detect
  import div_period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic edge_p
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end
  end

  // Edge is taken only from the last synchronizer stage, never an earlier one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d <= 1'b0;
      edge_p <= 1'b0;
    end else begin
      sync_d <= sync_q[SYNC_STAGES-1];
      edge_p <= sync_q[SYNC_STAGES-1] & ~sync_d;
    end
  end

endmodule

// File: rtl/div_period_meter.sv
// Measures the period of a divided clock in clk cycles, flags missing edges
// and reports lock once the period matches the programmed divide ratio.
module div_period_meter
  import div_period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sig_in,
  input  logic [3:0]          ndiv_exp,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                overflow,
  output logic                locked
);

  localparam logic [3:0]          LOCK_MAX = 4'(LOCK_COUNT);
  localparam logic [PERIOD_W-1:0] TOL_V    = PERIOD_W'(TOL);

  logic                edge_p;
  state_t              state;
  logic [PERIOD_W-1:0] cnt;
  logic [3:0]          match_cnt;
  logic [3:0]          match_next;
  logic [3:0]          ndiv_q;
  logic [PERIOD_W-1:0] exp_per;
  logic                in_tol;
  logic                ndiv_chg;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .edge_p (edge_p)
  );

  assign exp_per  = exp_period(ndiv_exp);
  assign in_tol   = abs_diff(cnt, exp_per) <= TOL_V;
  assign ndiv_chg = ndiv_exp != ndiv_q;

  always_comb begin
    match_next = '0;
    if (in_tol) begin
      match_next = (match_cnt == LOCK_MAX) ? match_cnt : match_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      match_cnt    <= '0;
      ndiv_q       <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
      locked       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      ndiv_q       <= ndiv_exp;
      if (!en) begin
        state     <= IDLE;
        cnt       <= '0;
        match_cnt <= '0;
        locked    <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (edge_p) begin
              cnt   <= 6'd1;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (edge_p) begin
              period       <= cnt;
              period_valid <= 1'b1;
              cnt          <= 6'd1;
              overflow     <= 1'b0;
              match_cnt    <= match_next;
              locked       <= (match_next == LOCK_MAX);
            end else if (cnt == PERIOD_SAT) begin
              // No edge for a full counter span: the divider has stopped.
              overflow  <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
              state     <= ARM;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
          default: state <= IDLE;
        endcase
        // A reprogrammed ratio invalidates the lock history but not the count.
        if (ndiv_chg) begin
          match_cnt <= '0;
          locked    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_period_meter.sv
// Directed bench for div_period_meter: lock, off-frequency, overflow,
// enable drop, ratio change and asynchronous reset scenarios.
module tb_div_period_meter;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       sig_in = 1'b0;
  logic [3:0] ndiv_exp = 4'd4;
  logic [5:0] period;
  logic       period_valid;
  logic       overflow;
  logic       locked;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_valid_cyc = 0;

  div_period_meter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sig_in       (sig_in),
    .ndiv_exp     (ndiv_exp),
    .period       (period),
    .period_valid (period_valid),
    .overflow     (overflow),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One sig_in period of length per starting with a rising edge now.
  // The valid it produces reports the distance back to the previous rise.
  task automatic send_period(input int per, input bit exp_valid, input int exp_per,
                             input bit exp_locked);
    bit want;
    sig_in = 1'b1;
    for (int j = 1; j <= per; j++) begin
      tick();
      if (j == per - per / 2) sig_in = 1'b0;
      want = exp_valid && (j == S + 2);
      checks++;
      if (period_valid !== want) begin
        errors++;
        $display("FAIL valid_timing cyc=%0d offset=%0d got=%b exp=%b", cyc, j, period_valid, want);
      end
      if (want) begin
        last_valid_cyc = cyc;
        checks++;
        if (period !== 6'(exp_per)) begin
          errors++;
          $display("FAIL period_value cyc=%0d got=%0d exp=%0d", cyc, period, exp_per);
        end
        checks++;
        if (locked !== exp_locked) begin
          errors++;
          $display("FAIL locked_at_valid cyc=%0d got=%b exp=%b", cyc, locked, exp_locked);
        end
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          $display("FAIL overflow_at_valid cyc=%0d got=%b exp=0", cyc, overflow);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({period, period_valid, overflow, locked} !== 9'd0) begin
      errors++;
      $display("FAIL %s got period=%0d valid=%b ovf=%b lock=%b exp all 0",
               tag, period, period_valid, overflow, locked);
    end
  endtask

  task automatic test_reset();
    #1;
    check_all_zero("reset_initial");
    tick();
    tick();
    check_all_zero("reset_held");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lock_nominal();
    en = 1'b1;
    ndiv_exp = 4'd4;
    tick();
    tick();
    send_period(6, 1'b0, 0, 1'b0);
    send_period(6, 1'b1, 6, 1'b0);
    send_period(6, 1'b1, 6, 1'b0);
    send_period(6, 1'b1, 6, 1'b0);
    send_period(6, 1'b1, 6, 1'b1);
    send_period(6, 1'b1, 6, 1'b1);
  endtask

  task automatic test_overflow();
    while (cyc < last_valid_cyc + 62) tick();
    checks++;
    if (overflow !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL ovf_before got ovf=%b lock=%b exp ovf=0 lock=1", overflow, locked);
    end
    tick();
    checks++;
    if (overflow !== 1'b1 || locked !== 1'b0 || period !== 6'd6) begin
      errors++;
      $display("FAIL ovf_set got ovf=%b lock=%b period=%0d exp ovf=1 lock=0 period=6",
               overflow, locked, period);
    end
    send_period(6, 1'b0, 0, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky_arm got=%b exp=1", overflow);
    end
    send_period(6, 1'b1, 6, 1'b0);
    send_period(6, 1'b1, 6, 1'b0);
    send_period(6, 1'b1, 6, 1'b0);
    send_period(6, 1'b1, 6, 1'b1);
  endtask

  task automatic test_en_drop();
    en = 1'b0;
    tick();
    checks++;
    if (locked !== 1'b0 || overflow !== 1'b0 || period !== 6'd6 || period_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_drop got lock=%b ovf=%b period=%0d valid=%b exp lock=0 ovf=0 period=6 valid=0",
               locked, overflow, period, period_valid);
    end
  endtask

  task automatic test_ndiv_change();
    en = 1'b1;
    tick();
    send_period(6, 1'b0, 0, 1'b0);
    send_period(6, 1'b1, 6, 1'b0);
    send_period(6, 1'b1, 6, 1'b0);
    send_period(6, 1'b1, 6, 1'b0);
    send_period(6, 1'b1, 6, 1'b1);
    ndiv_exp = 4'd6;
    tick();
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL ndiv_change_unlock got=%b exp=0", locked);
    end
    send_period(8, 1'b1, 7, 1'b0);
    send_period(8, 1'b1, 8, 1'b0);
    send_period(8, 1'b1, 8, 1'b0);
    send_period(8, 1'b1, 8, 1'b1);
  endtask

  task automatic test_off_frequency();
    en = 1'b0;
    tick();
    en = 1'b1;
    ndiv_exp = 4'd4;
    tick();
    send_period(10, 1'b0, 0, 1'b0);
    send_period(10, 1'b1, 10, 1'b0);
    send_period(10, 1'b1, 10, 1'b0);
    send_period(10, 1'b1, 10, 1'b0);
    send_period(10, 1'b1, 10, 1'b0);
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    send_period(7, 1'b0, 0, 1'b0);
    send_period(7, 1'b1, 7, 1'b0);
    send_period(7, 1'b1, 7, 1'b0);
    send_period(7, 1'b1, 7, 1'b0);
    send_period(7, 1'b1, 7, 1'b1);
  endtask

  task automatic test_reset_mid();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    send_period(6, 1'b0, 0, 1'b0);
    send_period(6, 1'b1, 6, 1'b0);
    sig_in = 1'b1;
    repeat (3) tick();
    sig_in = 1'b0;
    tick();
    checks++;
    if (period_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid got=%b exp=1", period_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_async");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("reset_release");
    send_period(6, 1'b0, 0, 1'b0);
    send_period(6, 1'b1, 6, 1'b0);
    send_period(6, 1'b1, 6, 1'b0);
  endtask

  initial begin
    test_reset();
    test_lock_nominal();
    test_overflow();
    test_en_drop();
    test_ndiv_change();
    test_off_frequency();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
